// File: rtl/bcd_addsub_serial_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the digit-serial BCD adder/subtractor.
//   bcd_digit_t : one packed BCD digit (4 bits)
//   state_t     : controller states (IDLE, ADD, FIX)
//   BCD_MAX     : largest legal BCD digit, also the nine's-complement base
//   BCD_CORR    : decimal correction added when a binary digit sum exceeds 9
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_addsub_serial_if.sv
// ---------------------------------------------------------------------------
// bcd_addsub_serial_if
// Request/result bundle of the serial BCD adder/subtractor.
//   start, sub, a, b             : request side (driven by the master)
//   busy, done, res, cout, neg, err : status/result side (driven by the unit)
// Modports: master (operand register side), slave (the arithmetic unit).
// ---------------------------------------------------------------------------
interface bcd_addsub_serial_if #(
    parameter int DIGITS = 4
);

    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   res;
    logic                  cout;
    logic                  neg;
    logic                  err;

    modport master (
        output start, sub, a, b,
        input  busy, done, res, cout, neg, err
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, res, cout, neg, err
    );

endinterface

// File: rtl/bcd_addsub_serial_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD correction adder.
//   x, y : input digits
//   cin  : carry in
//   s    : corrected result digit
//   cout : decimal carry out (binary sum was above 9)
// ---------------------------------------------------------------------------
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       cin,
    output bcd_digit_t s,
    output logic       cout
);

    logic [4:0] raw;

    // Plain binary sum first; anything past 9 is folded back into the
    // decimal range by adding 6, which also drops the 16s bit naturally.
    always_comb begin
        raw  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        s    = raw[3:0];
        cout = 1'b0;
        if (raw > 5'd9) begin
            s    = raw[3:0] + BCD_CORR;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// ---------------------------------------------------------------------------
// bcd_addsub_serial
// Digit-serial N-digit BCD adder/subtractor with sign-magnitude result.
// One digit is processed per clock through a single shared bcd_digit_add.
// Subtraction uses nine's complement plus an initial carry; a negative
// result is recovered by a second pass (FIX) taking its ten's complement.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd_addsub_serial_if.slave (start/sub/a/b in,
//           busy/done/res/cout/neg/err out)
// Optional feature macro: BCD_INPUT_CHECK_EN builds the invalid-digit check
// that drives err; without it err is tied low.
// ---------------------------------------------------------------------------
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_addsub_serial_if.slave    bus
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    state_t           state;
    state_t           state_next;

    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [W-1:0]     res_q;
    logic [CNT_W-1:0] cnt;
    logic             sub_q;
    logic             carry;
    logic             cout_q;
    logic             neg_q;
    logic             done_q;

    logic             load;
    logic             step;
    logic             enter_fix;
    logic             finish;
    logic             last;

    bcd_digit_t       dig_x;
    bcd_digit_t       dig_y;
    bcd_digit_t       dig_s;
    logic             dig_cout;
    logic [W+3:0]     res_cat;
    logic [W-1:0]     res_next;

    assign last = (cnt == LAST_DIGIT);

    // Operand selection for the shared digit adder. In ADD the low digits of
    // the operand shift registers are used, with B nine's-complemented for
    // subtraction. In FIX the current result digit is nine's-complemented
    // against zero so the running carry turns it into a ten's complement.
    always_comb begin
        dig_x = a_sr[3:0];
        dig_y = b_sr[3:0];
        if (state == FIX) begin
            dig_x = 4'd0;
            dig_y = BCD_MAX - res_q[3:0];
        end else if (sub_q) begin
            dig_y = BCD_MAX - b_sr[3:0];
        end
    end

    bcd_digit_add u_digit_add (
        .x    (dig_x),
        .y    (dig_y),
        .cin  (carry),
        .s    (dig_s),
        .cout (dig_cout)
    );

    // New digit enters at the MSB end while the consumed digit drops off the
    // LSB end; concatenating and shifting keeps this valid even for DIGITS=1.
    always_comb begin
        res_cat  = {dig_s, res_q} >> 4;
        res_next = res_cat[W-1:0];
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes. A subtraction that ends without a
    // carry out means A < B, so it detours through FIX before finishing.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        enter_fix  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                step = 1'b1;
                if (last) begin
                    if (sub_q && !dig_cout) begin
                        enter_fix  = 1'b1;
                        state_next = FIX;
                    end else begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            FIX: begin
                step = 1'b1;
                if (last) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand/result shift registers, digit counter, carry and the
    // held result flags. Flags are cleared on an accepted start and then
    // hold from done until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_q  <= '0;
            cnt    <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                a_sr   <= bus.a;
                b_sr   <= bus.b;
                sub_q  <= bus.sub;
                carry  <= bus.sub;
                cnt    <= '0;
                cout_q <= 1'b0;
                neg_q  <= 1'b0;
            end else if (step) begin
                a_sr  <= a_sr >> 4;
                b_sr  <= b_sr >> 4;
                res_q <= res_next;
                carry <= dig_cout;
                cnt   <= cnt + 1'b1;
                if (enter_fix) begin
                    neg_q <= 1'b1;
                    carry <= 1'b1;
                    cnt   <= '0;
                end
                if (finish && (state == ADD) && !sub_q) begin
                    cout_q <= dig_cout;
                end
            end
        end
    end

`ifdef BCD_INPUT_CHECK_EN
    logic err_q;
    logic bad_digit;

    // Flag any operand digit above 9 at the moment the request is accepted.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((bus.a[4*i +: 4] > BCD_MAX) || (bus.b[4*i +: 4] > BCD_MAX)) begin
                bad_digit = 1'b1;
            end
        end
    end

    // err is captured with the operands and holds until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (load) begin
            err_q <= bad_digit;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.res  = res_q;
    assign bus.cout = cout_q;
    assign bus.neg  = neg_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// ---------------------------------------------------------------------------
// tb_bcd_addsub_serial
// Directed self-checking bench for bcd_addsub_serial with DIGITS=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_addsub_serial;

    localparam int DIGITS = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    logic seen_done;

    bcd_addsub_serial_if #(.DIGITS(DIGITS)) bus ();

    bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counted, and reported with observed/expected on error.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; it is accepted at the next rising
    // edge (E0). Returns at the falling edge after E0 with start dropped.
    task automatic start_op(input logic s, input logic [15:0] av, input logic [15:0] bv);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Count rising edges after E0 until done is seen, bounded at 40.
    task automatic wait_done(input int from, output int cycles);
        cycles = from;
        while (bus.done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_res",  32'(bus.res),  32'h0);
        check("rst_cout", 32'(bus.cout), 32'h0);
        check("rst_neg",  32'(bus.neg),  32'h0);
        check("rst_err",  32'(bus.err),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1234 + 5678 = 6912
        start_op(1'b0, 16'h1234, 16'h5678);
        check("add1_busy", 32'(bus.busy), 32'h1);
        wait_done(0, cyc);
        check("add1_done", 32'(bus.done), 32'h1);
        check("add1_lat",  32'(cyc), 32'd4);
        check("add1_busy_at_done", 32'(bus.busy), 32'h0);
        check("add1_res",  32'(bus.res),  32'h6912);
        check("add1_cout", 32'(bus.cout), 32'h0);
        check("add1_neg",  32'(bus.neg),  32'h0);
        repeat (3) @(negedge clk);
        check("add1_hold_res",  32'(bus.res),  32'h6912);
        check("add1_done_pulse", 32'(bus.done), 32'h0);

        // 9999 + 0001 overflows
        start_op(1'b0, 16'h9999, 16'h0001);
        wait_done(0, cyc);
        check("add2_res",  32'(bus.res),  32'h0000);
        check("add2_cout", 32'(bus.cout), 32'h1);

        // 0000 + 0000
        @(negedge clk);
        start_op(1'b0, 16'h0000, 16'h0000);
        wait_done(0, cyc);
        check("add3_res",  32'(bus.res),  32'h0000);
        check("add3_cout", 32'(bus.cout), 32'h0);

        // 5000 - 1234 = 3766
        @(negedge clk);
        start_op(1'b1, 16'h5000, 16'h1234);
        wait_done(0, cyc);
        check("sub1_lat",  32'(cyc), 32'd4);
        check("sub1_res",  32'(bus.res),  32'h3766);
        check("sub1_neg",  32'(bus.neg),  32'h0);
        check("sub1_cout", 32'(bus.cout), 32'h0);

        // 1234 - 1234 = 0
        @(negedge clk);
        start_op(1'b1, 16'h1234, 16'h1234);
        wait_done(0, cyc);
        check("sub2_res", 32'(bus.res), 32'h0000);
        check("sub2_neg", 32'(bus.neg), 32'h0);

        // 0123 - 0456 = -0333, then back-to-back 0001 + 0001
        @(negedge clk);
        start_op(1'b1, 16'h0123, 16'h0456);
        wait_done(0, cyc);
        check("sub3_lat", 32'(cyc), 32'd8);
        check("sub3_res", 32'(bus.res), 32'h0333);
        check("sub3_neg", 32'(bus.neg), 32'h1);
        start_op(1'b0, 16'h0001, 16'h0001);
        check("b2b_busy", 32'(bus.busy), 32'h1);
        wait_done(0, cyc);
        check("b2b_lat", 32'(cyc), 32'd4);
        check("b2b_res", 32'(bus.res), 32'h0002);
        check("b2b_neg", 32'(bus.neg), 32'h0);

        // start while busy is ignored
        @(negedge clk);
        start_op(1'b0, 16'h1234, 16'h5678);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = 1'b1;
        bus.a     = 16'h0000;
        bus.b     = 16'h9999;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_done(3, cyc);
        check("ign_lat", 32'(cyc), 32'd4);
        check("ign_res", 32'(bus.res), 32'h6912);
        check("ign_neg", 32'(bus.neg), 32'h0);
        repeat (2) @(negedge clk);
        check("ign_idle", 32'(bus.busy), 32'h0);

        // Reset mid-ADD
        start_op(1'b0, 16'h1234, 16'h5678);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_res",  32'(bus.res),  32'h0);
        check("mid_rst_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check("mid_rst_no_done", 32'(seen_done), 32'h0);

        // Invalid digit in A: 00A0 + 0000 gives 0100 from digit correction
        start_op(1'b0, 16'h00A0, 16'h0000);
`ifdef BCD_INPUT_CHECK_EN
        check("err_flag", 32'(bus.err), 32'h1);
`else
        check("err_flag", 32'(bus.err), 32'h0);
`endif
        wait_done(0, cyc);
        check("err_res", 32'(bus.res), 32'h0100);
        check("err_lat", 32'(cyc), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
